// File: rtl/retire_monitor.sv
// retire_monitor: watches the core's retire stream, counts run cycles and retired
// instructions, keeps a short PC history and flags program end (self-loop halt or timeout).
//
// state     | meaning
// S_IDLE    | waiting for the first retire of a run
// S_RUN     | program executing, counters and history live
// S_HALTED  | PC repeated HALT_REPEAT times in a row; everything frozen
// S_TIMEOUT | run lasted TIMEOUT_CYCLES cycles; everything frozen
module retire_monitor #(
  parameter int HALT_REPEAT    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32,
  parameter int HIST_DEPTH     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_clear,
  input  logic [31:0]                   i_pc_debug,
  input  logic                          i_insn_vld,
  input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
  output logic [CNT_W-1:0]              o_cycle_cnt,
  output logic [CNT_W-1:0]              o_insn_cnt,
  output logic [31:0]                   o_last_pc,
  output logic [31:0]                   o_hist_pc,
  output logic [$clog2(HIST_DEPTH):0]   o_hist_cnt,
  output logic                          o_running,
  output logic                          o_halted,
  output logic                          o_timeout,
  output logic                          o_done
);

  localparam int IDX_W  = $clog2(HIST_DEPTH);
  localparam int HCNT_W = IDX_W + 1;
  localparam int RPT_W  = $clog2(HALT_REPEAT + 1);

  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [RPT_W-1:0]  RPT_LAST    = RPT_W'(HALT_REPEAT - 1);
  localparam logic [RPT_W-1:0]  RPT_ONE     = RPT_W'(1);
  localparam logic [HCNT_W-1:0] HIST_FULL   = HCNT_W'(HIST_DEPTH);
  localparam logic [HCNT_W-1:0] HCNT_ONE    = HCNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  insn_cnt;
  logic [CNT_W-1:0]  cycle_nxt;
  logic [CNT_W-1:0]  insn_nxt;
  logic [31:0]       last_pc;
  logic [RPT_W-1:0]  rpt_cnt;
  logic [31:0]       hist_mem [HIST_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDX_W-1:0]  rd_ptr;
  logic [HCNT_W-1:0] hist_cnt;
  logic [HCNT_W-1:0] hist_cnt_nxt;
  logic              same_pc;
  logic              halt_hit;

  // Counters stick at all-ones rather than wrapping.
  assign cycle_nxt    = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_ONE;
  assign insn_nxt     = (&insn_cnt) ? insn_cnt : insn_cnt + CNT_ONE;
  assign hist_cnt_nxt = (hist_cnt == HIST_FULL) ? hist_cnt : hist_cnt + HCNT_ONE;

  assign same_pc  = (i_pc_debug == last_pc);
  assign halt_hit = i_insn_vld && same_pc && (rpt_cnt == RPT_LAST);

  // wr_ptr points at the next free slot, so the newest entry sits one behind it.
  assign rd_ptr = wr_ptr - IDX_ONE - i_hist_idx;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      insn_cnt  <= '0;
      last_pc   <= '0;
      rpt_cnt   <= '0;
      wr_ptr    <= '0;
      hist_cnt  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (i_clear) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      insn_cnt  <= '0;
      last_pc   <= '0;
      rpt_cnt   <= '0;
      wr_ptr    <= '0;
      hist_cnt  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_insn_vld) begin
            state            <= (TIMEOUT_VAL == CNT_ONE) ? S_TIMEOUT : S_RUN;
            cycle_cnt        <= CNT_ONE;
            insn_cnt         <= CNT_ONE;
            last_pc          <= i_pc_debug;
            rpt_cnt          <= '0;
            hist_mem[wr_ptr] <= i_pc_debug;
            wr_ptr           <= wr_ptr + IDX_ONE;
            hist_cnt         <= hist_cnt_nxt;
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_nxt;
          if (i_insn_vld) begin
            insn_cnt         <= insn_nxt;
            last_pc          <= i_pc_debug;
            rpt_cnt          <= same_pc ? rpt_cnt + RPT_ONE : '0;
            hist_mem[wr_ptr] <= i_pc_debug;
            wr_ptr           <= wr_ptr + IDX_ONE;
            hist_cnt         <= hist_cnt_nxt;
          end
          // A halt on the timeout edge is reported as a halt.
          if (halt_hit) begin
            state <= S_HALTED;
          end else if (cycle_nxt == TIMEOUT_VAL) begin
            state <= S_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_cycle_cnt = cycle_cnt;
  assign o_insn_cnt  = insn_cnt;
  assign o_last_pc   = last_pc;
  assign o_hist_pc   = hist_mem[rd_ptr];
  assign o_hist_cnt  = hist_cnt;
  assign o_running   = (state == S_RUN);
  assign o_halted    = (state == S_HALTED);
  assign o_timeout   = (state == S_TIMEOUT);
  assign o_done      = o_halted | o_timeout;

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: table vectors, hand-written corner sequences and
// randomized retire streams checked against a queue-based reference model.
module tb_retire_monitor;
  localparam int HR = 4;
  localparam int TO = 20;
  localparam int CW = 32;
  localparam int HD = 8;
  localparam int IW = $clog2(HD);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          vld = 1'b0;
  logic [31:0]   pc = '0;
  logic [IW-1:0] idx = '0;
  logic [CW-1:0] o_cycle_cnt;
  logic [CW-1:0] o_insn_cnt;
  logic [31:0]   o_last_pc;
  logic [31:0]   o_hist_pc;
  logic [IW:0]   o_hist_cnt;
  logic          o_running;
  logic          o_halted;
  logic          o_timeout;
  logic          o_done;

  retire_monitor #(
    .HALT_REPEAT(HR), .TIMEOUT_CYCLES(TO), .CNT_W(CW), .HIST_DEPTH(HD)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr),
    .i_pc_debug(pc), .i_insn_vld(vld), .i_hist_idx(idx),
    .o_cycle_cnt(o_cycle_cnt), .o_insn_cnt(o_insn_cnt), .o_last_pc(o_last_pc),
    .o_hist_pc(o_hist_pc), .o_hist_cnt(o_hist_cnt), .o_running(o_running),
    .o_halted(o_halted), .o_timeout(o_timeout), .o_done(o_done)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the run is the list of PCs retired since IDLE.
  bit          m_run, m_halt, m_to;
  int          m_cyc;
  logic [31:0] m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_halt = 0; m_to = 0; m_cyc = 0;
    m_q.delete();
  endfunction

  function automatic bit tail_repeats(input logic [31:0] p);
    if (m_q.size() < HR + 1) return 0;
    for (int k = 0; k <= HR; k++)
      if (m_q[m_q.size()-1-k] != p) return 0;
    return 1;
  endfunction

  function automatic void model_step(input bit v, input logic [31:0] p, input bit c);
    if (c) begin
      model_reset();
    end else if (m_halt || m_to) begin
    end else if (!m_run) begin
      if (v) begin
        m_run = 1; m_cyc = 1; m_q.delete(); m_q.push_back(p);
        if (m_cyc == TO) begin m_run = 0; m_to = 1; end
      end
    end else begin
      m_cyc++;
      if (v) m_q.push_back(p);
      if (v && tail_repeats(p)) begin m_run = 0; m_halt = 1; end
      else if (m_cyc == TO) begin m_run = 0; m_to = 1; end
    end
  endfunction

  task automatic check_all();
    int n;
    n = m_q.size();
    chk("cycle_cnt", o_cycle_cnt, 32'(m_cyc));
    chk("insn_cnt", o_insn_cnt, 32'(n));
    chk("last_pc", o_last_pc, (n > 0) ? m_q[n-1] : 32'h0);
    chk("hist_cnt", 32'(o_hist_cnt), 32'((n < HD) ? n : HD));
    chk("running", 32'(o_running), 32'(m_run));
    chk("halted", 32'(o_halted), 32'(m_halt));
    chk("timeout", 32'(o_timeout), 32'(m_to));
    chk("done", 32'(o_done), 32'(m_halt | m_to));
    for (int i = 0; i < HD; i++) begin
      idx = IW'(i);
      #1;
      chk($sformatf("hist[%0d]", i), o_hist_pc, (i < n) ? m_q[n-1-i] : 32'h0);
    end
    idx = '0;
  endtask

  task automatic step(input bit v, input logic [31:0] p, input bit c);
    vld = v; pc = p; clr = c;
    @(posedge clk);
    model_step(v, p, c);
    #1;
    check_all();
  endtask

  task automatic hist_at(input int i, output logic [31:0] val);
    idx = IW'(i);
    #1;
    val = o_hist_pc;
    idx = '0;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          c;
    int          insn;
    int          cyc;
    logic [31:0] last;
    bit          run;
    bit          halt;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] hv;
  logic [31:0] rp;
  bit          rv, rc;

  initial begin
    tbl[0]  = '{1, 32'h0, 0, 1, 1, 32'h0, 1, 0};
    tbl[1]  = '{1, 32'h4, 0, 2, 2, 32'h4, 1, 0};
    tbl[2]  = '{1, 32'h8, 0, 3, 3, 32'h8, 1, 0};
    tbl[3]  = '{1, 32'h8, 0, 4, 4, 32'h8, 1, 0};
    tbl[4]  = '{1, 32'h8, 0, 5, 5, 32'h8, 1, 0};
    tbl[5]  = '{0, 32'h8, 0, 5, 6, 32'h8, 1, 0};
    tbl[6]  = '{1, 32'h8, 0, 6, 7, 32'h8, 1, 0};
    tbl[7]  = '{1, 32'h8, 0, 7, 8, 32'h8, 0, 1};
    tbl[8]  = '{1, 32'h8, 0, 7, 8, 32'h8, 0, 1};
    tbl[9]  = '{1, 32'hC, 0, 7, 8, 32'h8, 0, 1};
    tbl[10] = '{0, 32'h0, 1, 0, 0, 32'h0, 0, 0};

    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) step(0, 32'h0, 0);
    chk("idle_running", 32'(o_running), 32'h0);
    chk("idle_cycle", o_cycle_cnt, 32'h0);
    chk("idle_insn", o_insn_cnt, 32'h0);
    chk("idle_done", 32'(o_done), 32'h0);

    // Four retires, two stalls
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), 0);
    step(0, 32'h0, 0);
    step(0, 32'h0, 0);
    chk("seq_insn", o_insn_cnt, 32'd4);
    chk("seq_cycle", o_cycle_cnt, 32'd6);
    chk("seq_last", o_last_pc, 32'hC);
    chk("seq_hcnt", 32'(o_hist_cnt), 32'd4);
    hist_at(0, hv); chk("seq_hist0", hv, 32'hC);
    hist_at(3, hv); chk("seq_hist3", hv, 32'h0);
    step(0, 32'h0, 1);

    // Halt sequence from the vector table
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].c);
      chk($sformatf("tbl%0d_insn", i), o_insn_cnt, 32'(tbl[i].insn));
      chk($sformatf("tbl%0d_cycle", i), o_cycle_cnt, 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_last", i), o_last_pc, tbl[i].last);
      chk($sformatf("tbl%0d_run", i), 32'(o_running), 32'(tbl[i].run));
      chk($sformatf("tbl%0d_halt", i), 32'(o_halted), 32'(tbl[i].halt));
    end

    // Timeout with alternating PCs
    for (int i = 0; i < 25; i++) begin
      step(1, (i % 2 == 0) ? 32'h0 : 32'h4, 0);
      if (i == 18) chk("to_before", 32'(o_timeout), 32'h0);
      if (i == 19) begin
        chk("to_hit", 32'(o_timeout), 32'h1);
        chk("to_cycle", o_cycle_cnt, 32'd20);
      end
    end
    chk("to_frozen_cycle", o_cycle_cnt, 32'd20);
    chk("to_frozen_insn", o_insn_cnt, 32'd20);
    chk("to_done", 32'(o_done), 32'h1);
    step(0, 32'h0, 1);

    // Halt completes on the timeout edge
    step(1, 32'h40, 0);
    for (int i = 0; i < 15; i++) step(0, 32'h40, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h40, 0);
    chk("both_halted", 32'(o_halted), 32'h1);
    chk("both_timeout", 32'(o_timeout), 32'h0);
    chk("both_cycle", o_cycle_cnt, 32'd20);
    chk("both_insn", o_insn_cnt, 32'd5);
    step(0, 32'h0, 1);

    // History wrap then clear
    for (int i = 0; i < 10; i++) step(1, 32'(4 * i), 0);
    hist_at(0, hv); chk("wrap_hist0", hv, 32'h24);
    hist_at(7, hv); chk("wrap_hist7", hv, 32'h08);
    chk("wrap_hcnt", 32'(o_hist_cnt), 32'd8);
    step(0, 32'h0, 1);
    chk("clr_cycle", o_cycle_cnt, 32'h0);
    chk("clr_insn", o_insn_cnt, 32'h0);
    chk("clr_last", o_last_pc, 32'h0);
    chk("clr_hcnt", 32'(o_hist_cnt), 32'h0);
    chk("clr_running", 32'(o_running), 32'h0);
    chk("clr_done", 32'(o_done), 32'h0);
    hist_at(0, hv); chk("clr_hist0", hv, 32'h0);

    // Async reset mid-run, checked before any clock edge
    for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(4 * i), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_running", 32'(o_running), 32'h0);
    chk("arst_cycle", o_cycle_cnt, 32'h0);
    chk("arst_insn", o_insn_cnt, 32'h0);
    chk("arst_last", o_last_pc, 32'h0);
    hist_at(0, hv); chk("arst_hist0", hv, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'h200, 0);
    chk("arst_fresh_insn", o_insn_cnt, 32'd1);

    // Randomized retire streams against the model
    rp = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      if (m_halt || m_to) rc = ($urandom_range(0, 3) == 0);
      else rc = ($urandom_range(0, 99) == 0);
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) rp = 32'($urandom_range(0, 7)) << 2;
      step(rv, rp, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
